serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 6, operand/sum width in bits (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand set presented.
REQ-005 SHALL have port: in_ready  output  1  controller can accept operands.
REQ-006 SHALL have port: x  input  WIDTH  operand X.
REQ-007 SHALL have port: y  input  WIDTH  operand Y.
REQ-008 SHALL have port: cin  input  1  carry-in.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: s  output  WIDTH  sum, meaningful only while out_valid=1.
REQ-012 SHALL have port: cout  output  1  carry-out, meaningful only while out_valid=1.
REQ-013 SHALL have port: busy  output  1  high in SHIFT state.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE: in_ready=1; on in_valid=1 at rising edge, SHALL capture x, y, cin into operand shift registers and carry flop, clear bit counter and sum register, go to SHIFT.
REQ-016 in_ready SHALL be 1 only in IDLE; x/y/cin SHALL be ignored in any other state.
REQ-017 SHIFT: each cycle SHALL add operand LSBs plus carry flop via a one-bit full adder, shift sum bit into sum register MSB side (LSB-first result), shift operands right by one, update carry flop, increment bit counter.
REQ-018 SHIFT SHALL last exactly WIDTH cycles; on edge where bit counter = WIDTH-1, go to DONE.
REQ-019 Latency: operands accepted at edge k SHALL give out_valid=1 from edge k+WIDTH onward (WIDTH=6: edge k+6).
REQ-020 DONE: out_valid=1, s = (x+y+cin) mod 2^WIDTH, cout = bit WIDTH of x+y+cin; s and cout SHALL stay stable until handshake.
REQ-021 DONE with out_ready=1 at edge SHALL go to IDLE; out_ready=0 SHALL hold DONE indefinitely (back-pressure).
REQ-022 No bypass: acceptance of new operands SHALL NOT occur in the same edge as result handshake; next acceptance earliest one cycle after DONE exit.
REQ-023 Bit counter SHALL be clog2(WIDTH) bits, never wrap during SHIFT, and be cleared on entry to SHIFT.
REQ-024 out_ready in IDLE/SHIFT and in_valid outside IDLE SHALL have no effect.
REQ-025 Throughput: one addition per WIDTH+2 cycles with out_ready held high.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, s=0, cout=0, counter=0, carry flop=0, operand registers=0.
REQ-027 rst asserted mid-SHIFT or in DONE SHALL discard the operation; no result SHALL be produced for it.
REQ-028 First acceptance after rst deassertion SHALL be possible at the first rising edge with rst=0.

Structure
REQ-029 Package serial_add_pkg SHALL hold state enum type (IDLE/SHIFT/DONE) and default width constant.
REQ-030 One sub-module SHALL exist: bit_adder_cell (combinational one-bit full adder: a, b, ci -> s, co); single instance.
REQ-031 All sequential logic SHALL reside in serial_add_ctrl; no generated clocks.

Verification
REQ-032 x=001011, y=010101, cin=1 -> after 6 SHIFT cycles s=100001, cout=0, out_valid at edge k+6.
REQ-033 x=101010, y=010101, cin=1 -> s=000000, cout=1.
REQ-034 x=111111, y=111111, cin=1 -> s=111111, cout=1; x=111111, y=000000, cin=0 -> s=111111, cout=0.
REQ-035 Back-pressure: out_ready=0 for 10 cycles in DONE -> out_valid, s, cout stable, in_ready=0; then out_ready=1 -> IDLE next edge.
REQ-036 rst pulse at 3rd SHIFT cycle -> immediate IDLE, out_valid never rises; next op x=000001, y=000001, cin=0 -> s=000010, cout=0.
REQ-037 Random 1000 operand sets vs. reference sum model, out_ready randomly toggled -> zero mismatches, no lost or duplicated results.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit counter needs at least one bit even for the narrowest operands.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bit_adder_cell.sv
// One-bit full adder, purely combinational; no latency, no flow control.
module bit_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: accepts x/y/cin in IDLE, adds LSB-first over WIDTH cycles, result valid WIDTH edges after accept.
// Result is held in DONE until out_ready; no accept on the handshake edge, so one op per WIDTH+2 cycles.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fa_s;
    logic fa_co;

    bit_adder_cell u_fa (
        .a  (x_q[0]),
        .b  (y_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y;
                    carry_d = cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Sum bits enter at the MSB so the first (LSB) bit ends up at bit 0.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                x_d     = x_q >> 1;
                y_d     = y_q >> 1;
                carry_d = fa_co;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign s         = out_valid ? sum_q : '0;
    assign cout      = out_valid & carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl against an arithmetic sum model.
module tb_serial_add_ctrl;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         busy;

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        x = a;
        y = b;
        cin = c;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges until out_valid is seen, bounded at 50.
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [W:0] e;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x = '1;
        y = '1;
        cin = 1'b1;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || s !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b s=%b cout=%b, expected 1 0 0 0 0",
                     in_ready, out_valid, busy, s, cout);
        end
        out_ready = 1'b0;
        x = 6'b000111;
        y = 6'b001001;
        cin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_accept: busy=%b in_ready=%b, expected busy=1 in_ready=0", busy, in_ready);
        end
        e = ref_sum(6'b000111, 6'b001001, 1'b0);
        wait_done(n);
        checks++;
        if (n != W || {cout, s} !== e) begin
            errors++;
            $display("FAIL first_op: latency=%0d sum=%b, expected latency=%0d sum=%b", n, {cout, s}, W, e);
        end
        handshake();
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic         vc [6];
        logic [W:0]   e;
        int n;
        va = '{6'b001011, 6'b101010, 6'b111111, 6'b111111, 6'b000000, 6'b100000};
        vb = '{6'b010101, 6'b010101, 6'b111111, 6'b000000, 6'b000000, 6'b100000};
        vc = '{1'b1,      1'b1,      1'b1,      1'b0,      1'b0,      1'b0};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d idle_ready: in_ready=%b, expected 1", i, in_ready);
            end
            // Assert out_ready through IDLE/SHIFT; it must not matter there.
            out_ready = 1'b1;
            start_op(va[i], vb[i], vc[i]);
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d shift_flags: busy=%b out_valid=%b, expected 1 0", i, busy, out_valid);
            end
            out_ready = 1'b0;
            e = ref_sum(va[i], vb[i], vc[i]);
            wait_done(n);
            checks++;
            if (n != W) begin
                errors++;
                $display("FAIL vec%0d latency: got %0d edges, expected %0d", i, n, W);
            end
            checks++;
            if ({cout, s} !== e || busy !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d sum: got cout=%b s=%b busy=%b, expected cout=%b s=%b busy=0",
                         i, cout, s, busy, e[W], e[W-1:0]);
            end
            handshake();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d exit: out_valid=%b in_ready=%b, expected 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s0;
        logic         c0;
        logic [W:0]   e;
        logic [W-1:0] nx;
        int n;
        start_op(6'h2d, 6'h13, 1'b0);
        wait_done(n);
        s0 = s;
        c0 = cout;
        e = ref_sum(6'h2d, 6'h13, 1'b0);
        checks++;
        if (n != W || {c0, s0} !== e) begin
            errors++;
            $display("FAIL bp_result: latency=%0d sum=%b, expected latency=%0d sum=%b", n, {c0, s0}, W, e);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            x = W'($urandom);
            y = W'($urandom);
            cin = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || s !== s0 || cout !== c0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%b s=%b cout=%b in_ready=%b, expected 1 %b %b 0",
                         i, out_valid, s, cout, in_ready, s0, c0);
            end
        end
        nx = 6'b011011;
        x = nx;
        y = 6'b000101;
        cin = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_bypass: out_valid=%b in_ready=%b busy=%b, expected 0 1 0",
                     out_valid, in_ready, busy);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept: busy=%b, expected 1", busy);
        end
        e = ref_sum(nx, 6'b000101, 1'b1);
        wait_done(n);
        checks++;
        if (n != W || {cout, s} !== e) begin
            errors++;
            $display("FAIL bp_next_result: latency=%0d sum=%b, expected latency=%0d sum=%b", n, {cout, s}, W, e);
        end
        handshake();
    endtask

    task automatic test_reset_mid_shift();
        logic       seen = 1'b0;
        logic [W:0] e;
        int n;
        start_op(6'b110011, 6'b011110, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || s !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: in_ready=%b busy=%b out_valid=%b s=%b cout=%b, expected 1 0 0 0 0",
                     in_ready, busy, out_valid, s, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard: out_valid rose after reset, expected it to stay 0");
        end
        start_op(6'b000001, 6'b000001, 1'b0);
        e = ref_sum(6'b000001, 6'b000001, 1'b0);
        wait_done(n);
        checks++;
        if (n != W || {cout, s} !== e) begin
            errors++;
            $display("FAIL rst_next_op: latency=%0d sum=%b, expected latency=%0d sum=%b", n, {cout, s}, W, e);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        logic [W:0] e;
        int nres = 0;
        x = 6'b100111;
        y = 6'b011010;
        cin = 1'b1;
        e = ref_sum(6'b100111, 6'b011010, 1'b1);
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            in_valid = (acc_cyc.size() < 3);
            if (in_valid && in_ready) acc_cyc.push_back(c);
            if (out_valid) begin
                nres++;
                checks++;
                if ({cout, s} !== e) begin
                    errors++;
                    $display("FAIL b2b_sum%0d: got %b, expected %b", nres, {cout, s}, e);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (acc_cyc.size() != 3 || nres != 3) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d results=%0d, expected 3 3", acc_cyc.size(), nres);
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != W + 2 || acc_cyc[2] - acc_cyc[1] != W + 2) begin
                errors++;
                $display("FAIL b2b_period: spacing %0d,%0d cycles, expected %0d",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], W + 2);
            end
        end
    endtask

    task automatic test_random();
        logic [W:0]   exp_q[$];
        logic [W:0]   held_val = '0;
        logic         held = 1'b0;
        int acc = 0;
        int nres = 0;
        int cyc = 0;
        while ((acc < 1000 || exp_q.size() != 0) && cyc < 40000) begin
            in_valid = (acc < 1000) && ($urandom_range(0, 3) != 0);
            x = W'($urandom);
            y = W'($urandom);
            cin = 1'($urandom);
            out_ready = 1'($urandom);
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sum(x, y, cin));
                acc++;
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || {cout, s} !== held_val) begin
                    errors++;
                    $display("FAIL rnd_hold: out_valid=%b sum=%b, expected 1 %b", out_valid, {cout, s}, held_val);
                end
            end
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    nres++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rnd_extra: result %b with nothing outstanding", {cout, s});
                    end else begin
                        if ({cout, s} !== exp_q[0]) begin
                            errors++;
                            $display("FAIL rnd_sum%0d: got %b, expected %b", nres, {cout, s}, exp_q[0]);
                        end
                        void'(exp_q.pop_front());
                    end
                end else begin
                    held = 1'b1;
                    held_val = {cout, s};
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (acc != 1000 || nres != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_totals: accepted=%0d results=%0d pending=%0d, expected 1000 1000 0",
                     acc, nres, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
